note_lane_scheduler: RTL and testbench
======================================

Name: note_lane_scheduler

Overview:
- Game sequencer for the drum-hero datapath. Runs the game state machine and owns the four falling note lines.
- Generates each line's vertical position and its 5-bit drum pattern, and paces line launches.
- Feeds posL1..posL4 and linea1..linea4 to the scoring block and the video renderer.
- Consumes the scorer's puntuacion and perdio to set speed and end the game, and issues the score-clear pulse.

Parameters:
- Y_MAX, 479, bottom row. A line at Y_MAX is counted as missed by the scorer.
- SPAWN_GAP, 40, minimum number of ticks between line launches (>=1).
- LFSR_SEED, 8'hA5, non-zero reset value of the pattern LFSR.
- LEVEL_SHIFT, 4, points per speed level = 2^LEVEL_SHIFT.
- MAX_STEP, 4, maximum pixels advanced per tick.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-clk frame pulse; all line motion happens only on clk cycles with tick=1
- start  in  1  player start button, already debounced, level-sensitive
- perdio  in  1  lose flag from the scorer
- puntuacion  in  13  current score from the scorer
- posL1..posL4  out  10 each  line vertical position; 0 = slot free
- linea1..linea4  out  5 each  drum pattern of the line; 0 while the slot is free
- clear_score  out  1  drives the scorer's synchronous reset
- estado  out  2  0 IDLE, 1 START, 2 PLAYING, 3 GAME_OVER
- jugando  out  1  high when estado==PLAYING

Behaviour:
- Reset values: estado=IDLE; all posLn=0 and lineaN=0; clear_score=0; gap counter=0; guard counter=0; LFSR=LFSR_SEED. All outputs are registered.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances every clk in all states. pattern = lfsr[4:0]; if that is zero, pattern = 5'b00001.
- IDLE: start=1 -> START.
- START: lasts exactly 2 clk cycles.
  - clear_score=1 for both cycles.
  - Slots are cleared to 0 and the gap counter is cleared to 0.
  - perdio is ignored, so the scorer's stale lose flag cannot end the new game.
  - After the 2 cycles -> PLAYING.
- PLAYING:
  - perdio=1 -> GAME_OVER on the next edge. perdio has priority over a tick in the same cycle: no slot update happens that cycle.
  - start is ignored.
- GAME_OVER:
  - Positions and patterns are frozen for display.
  - start=1 -> START (restart).
- Tick processing (PLAYING, tick=1), single clk. All decisions use pre-tick values.
  - step = min(1 + (puntuacion >> LEVEL_SHIFT), MAX_STEP).
  - Active slot with pos==Y_MAX -> pos=0, linea=0 (retired).
  - Active slot with pos<Y_MAX -> pos = min(pos+step, Y_MAX). The sum is computed 11 bits wide before clamping. Every line therefore sits at exactly Y_MAX for one full tick period.
  - Spawn: if gap==0 and at least one slot was free before this tick, the lowest-index such slot gets pos=1 and linea=pattern, then gap=SPAWN_GAP-1.
  - Spawn when no slot is free: gap stays 0 and the spawn is retried every tick.
  - If no spawn: gap decrements when non-zero.
  - A slot freed in this tick cannot be respawned in the same tick.
  - At most one spawn per tick.
- Non-tick cycles: slots and gap hold.
- tick outside PLAYING has no effect.
- Asynchronous reset mid-game forces the IDLE reset values immediately.

Decomposition:
- Shared package game_pkg:
  - state encoding localparams: ST_IDLE, ST_START, ST_PLAYING, ST_GAMEOVER
  - Y_MAX
  - position width 10, pattern width 5, score width 13
- One sub-module, lane_slot: holds one position/pattern register pair.
  - Inputs: advance, step, spawn, pattern, clear.
  - Output: free.
- Instantiated 4 times. Spawn priority, gap counter, LFSR and FSM live in the top module.

Test Plan:
- Reset, then start held one clk -> estado 1 for exactly 2 clks with clear_score=1, then estado=2 and jugando=1. A perdio=1 during START is ignored.
- First tick in PLAYING, LFSR_SEED=8'hA5 -> posL1=1 and linea1=5'b00101, posL2..4=0. With SPAWN_GAP=40, the next spawn lands in slot 2 exactly 40 ticks later.
- puntuacion=0 (step 1) -> posL1 reaches 479 after 478 further ticks, holds 479 for one tick, then returns to 0 with linea1=0.
- puntuacion=16 -> step 2; puntuacion=200 -> step clamped to 4. A line at pos 477 with step 4 goes to 479, never 481.
- SPAWN_GAP=1 with all 4 slots active -> no spawn and gap stays 0. When slot 1 retires at tick t, slot 1 is respawned at tick t+1, not t.
- perdio=1 coinciding with tick in PLAYING -> estado=3 and positions unchanged. Later start -> START, slots cleared, clear_score=1 for 2 clks.

Source files
------------

// File: rtl/game_pkg.sv
// Shared widths, state encoding and LFSR step for the drum-hero game sequencer.
package game_pkg;

    localparam int unsigned POS_W     = 10;
    localparam int unsigned PAT_W     = 5;
    localparam int unsigned SCORE_W   = 13;
    localparam int unsigned STEP_W    = 4;
    localparam int unsigned GAP_W     = 16;
    localparam int unsigned NUM_SLOTS = 4;

    // Bottom row; a line sitting here is counted as missed by the scorer.
    localparam logic [POS_W-1:0] Y_MAX = 10'd479;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_START    = 2'd1,
        ST_PLAYING  = 2'd2,
        ST_GAMEOVER = 2'd3
    } state_e;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/note_lane_scheduler_if.sv
// Game-side bundle between the scheduler, the scorer and the video renderer.
interface note_lane_scheduler_if;
    import game_pkg::*;

    logic                 tick;
    logic                 start;
    logic                 perdio;
    logic [SCORE_W-1:0]   puntuacion;
    logic [POS_W-1:0]     posL1;
    logic [POS_W-1:0]     posL2;
    logic [POS_W-1:0]     posL3;
    logic [POS_W-1:0]     posL4;
    logic [PAT_W-1:0]     linea1;
    logic [PAT_W-1:0]     linea2;
    logic [PAT_W-1:0]     linea3;
    logic [PAT_W-1:0]     linea4;
    logic                 clear_score;
    logic [1:0]           estado;
    logic                 jugando;

    // Scheduler side.
    modport master (
        input  tick, start, perdio, puntuacion,
        output posL1, posL2, posL3, posL4, linea1, linea2, linea3, linea4,
        output clear_score, estado, jugando
    );

    // Scorer / renderer / player side.
    modport slave (
        output tick, start, perdio, puntuacion,
        input  posL1, posL2, posL3, posL4, linea1, linea2, linea3, linea4,
        input  clear_score, estado, jugando
    );

endinterface

// File: rtl/lane_slot.sv
// One falling-note slot: vertical position plus drum pattern, 0 position means free.
module lane_slot
    import game_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic [STEP_W-1:0] step,
    input  logic              spawn,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              clear,
    output logic [POS_W-1:0]  pos,
    output logic [PAT_W-1:0]  linea,
    output logic              free
);

    logic [POS_W-1:0] pos_q, pos_d;
    logic [PAT_W-1:0] linea_q, linea_d;
    logic [POS_W:0]   sum;

    // Next position: clear wins, then retire/advance, then spawn into a free slot.
    always_comb begin
        pos_d   = pos_q;
        linea_d = linea_q;
        // One extra bit so pos+step cannot wrap before the clamp.
        sum     = (POS_W+1)'(pos_q) + (POS_W+1)'(step);
        if (clear) begin
            pos_d   = '0;
            linea_d = '0;
        end else begin
            if (advance) begin
                if (pos_q == Y_MAX) begin
                    pos_d   = '0;
                    linea_d = '0;
                end else if (pos_q != '0) begin
                    pos_d = (sum > (POS_W+1)'(Y_MAX)) ? Y_MAX : sum[POS_W-1:0];
                end
            end
            if (spawn) begin
                pos_d   = POS_W'(1);
                linea_d = pattern;
            end
        end
    end

    // Slot registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q   <= '0;
            linea_q <= '0;
        end else begin
            pos_q   <= pos_d;
            linea_q <= linea_d;
        end
    end

    assign pos   = pos_q;
    assign linea = linea_q;
    assign free  = (pos_q == '0);

endmodule

// File: rtl/note_lane_scheduler.sv
// Game sequencer: state machine, launch pacing, pattern LFSR and four note slots.
module note_lane_scheduler
    import game_pkg::*;
#(
    parameter int unsigned SPAWN_GAP   = 40,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5,
    parameter int unsigned LEVEL_SHIFT = 4,
    parameter int unsigned MAX_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    note_lane_scheduler_if.master bus
);

    state_e             state_q, state_d;
    logic               guard_q, guard_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic               clear_score_q, clear_score_d;
    logic               jugando_q, jugando_d;

    logic               tick_go;
    logic               slot_clear;
    logic               found;
    logic [SCORE_W:0]   level_step;
    logic [STEP_W-1:0]  step;
    logic [PAT_W-1:0]   pattern;
    logic [NUM_SLOTS-1:0] free_vec;
    logic [NUM_SLOTS-1:0] spawn_vec;
    logic [POS_W-1:0]   pos_arr [NUM_SLOTS];
    logic [PAT_W-1:0]   lin_arr [NUM_SLOTS];

    // Game FSM; START holds for two cycles via guard_q and ignores the stale perdio.
    always_comb begin
        state_d = state_q;
        guard_d = guard_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_START;
                    guard_d = 1'b0;
                end
            end
            ST_START: begin
                if (guard_q) begin
                    state_d = ST_PLAYING;
                    guard_d = 1'b0;
                end else begin
                    guard_d = 1'b1;
                end
            end
            ST_PLAYING: begin
                if (bus.perdio) state_d = ST_GAMEOVER;
            end
            ST_GAMEOVER: begin
                if (bus.start) begin
                    state_d = ST_START;
                    guard_d = 1'b0;
                end
            end
        endcase
        clear_score_d = (state_d == ST_START);
        jugando_d     = (state_d == ST_PLAYING);
    end

    // Speed level, pattern and launch pacing; all decisions use pre-tick slot state.
    always_comb begin
        lfsr_d     = lfsr_next(lfsr_q);
        pattern    = (lfsr_q[4:0] == 5'd0) ? 5'd1 : lfsr_q[4:0];
        level_step = (SCORE_W+1)'(bus.puntuacion >> LEVEL_SHIFT) + (SCORE_W+1)'(1);
        step       = (level_step > (SCORE_W+1)'(MAX_STEP)) ? STEP_W'(MAX_STEP)
                                                           : level_step[STEP_W-1:0];
        // perdio beats a coincident tick so the final frame stays on screen.
        tick_go    = (state_q == ST_PLAYING) && bus.tick && !bus.perdio;
        slot_clear = (state_q == ST_START);
        spawn_vec  = '0;
        found      = 1'b0;
        gap_d      = gap_q;
        if (slot_clear) begin
            gap_d = '0;
        end else if (tick_go) begin
            if ((gap_q == '0) && (|free_vec)) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (free_vec[i] && !found) begin
                        spawn_vec[i] = 1'b1;
                        found        = 1'b1;
                    end
                end
                gap_d = GAP_W'(SPAWN_GAP - 1);
            end else if (gap_q != '0) begin
                gap_d = gap_q - GAP_W'(1);
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            guard_q       <= 1'b0;
            gap_q         <= '0;
            lfsr_q        <= LFSR_SEED;
            clear_score_q <= 1'b0;
            jugando_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            guard_q       <= guard_d;
            gap_q         <= gap_d;
            lfsr_q        <= lfsr_d;
            clear_score_q <= clear_score_d;
            jugando_q     <= jugando_d;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        lane_slot u_slot (
            .clk     (clk),
            .reset   (reset),
            .advance (tick_go),
            .step    (step),
            .spawn   (spawn_vec[g]),
            .pattern (pattern),
            .clear   (slot_clear),
            .pos     (pos_arr[g]),
            .linea   (lin_arr[g]),
            .free    (free_vec[g])
        );
    end

    assign bus.posL1       = pos_arr[0];
    assign bus.posL2       = pos_arr[1];
    assign bus.posL3       = pos_arr[2];
    assign bus.posL4       = pos_arr[3];
    assign bus.linea1      = lin_arr[0];
    assign bus.linea2      = lin_arr[1];
    assign bus.linea3      = lin_arr[2];
    assign bus.linea4      = lin_arr[3];
    assign bus.clear_score = clear_score_q;
    assign bus.estado      = state_q;
    assign bus.jugando     = jugando_q;

endmodule

// File: tb/tb_note_lane_scheduler.sv
// Bench for note_lane_scheduler: default instance plus a SPAWN_GAP=1 instance.
module tb_note_lane_scheduler;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    note_lane_scheduler_if bus_a ();
    note_lane_scheduler_if bus_b ();

    note_lane_scheduler u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    note_lane_scheduler #(.SPAWN_GAP(1)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    logic [9:0] pos_a [4];
    logic [4:0] lin_a [4];
    logic [9:0] pos_b [4];
    logic [4:0] lin_b [4];
    assign pos_a[0] = bus_a.posL1;  assign pos_a[1] = bus_a.posL2;
    assign pos_a[2] = bus_a.posL3;  assign pos_a[3] = bus_a.posL4;
    assign lin_a[0] = bus_a.linea1; assign lin_a[1] = bus_a.linea2;
    assign lin_a[2] = bus_a.linea3; assign lin_a[3] = bus_a.linea4;
    assign pos_b[0] = bus_b.posL1;  assign pos_b[1] = bus_b.posL2;
    assign pos_b[2] = bus_b.posL3;  assign pos_b[3] = bus_b.posL4;
    assign lin_b[0] = bus_b.linea1; assign lin_b[1] = bus_b.linea2;
    assign lin_b[2] = bus_b.linea3; assign lin_b[3] = bus_b.linea4;

    int errors = 0;
    int checks = 0;

    // Reference LFSR: taps 8,6,5,4, seed A5, steps every clock out of reset.
    logic [7:0] m_lfsr;
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 8'hA5;
        else       m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
    end

    // Reference slot model and spawn scoreboard.
    int         m_pos [4];
    logic [4:0] m_lin [4];
    int         m_gap;
    int         gap_reload;
    typedef struct { int slot; logic [4:0] pat; } spawn_t;
    spawn_t sb [$];

    typedef struct { logic [12:0] pts; int step; int nticks; } phase_t;
    phase_t ph [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9:0] get_pos(input int w, input int i);
        return (w == 0) ? pos_a[i] : pos_b[i];
    endfunction

    function automatic logic [4:0] get_lin(input int w, input int i);
        return (w == 0) ? lin_a[i] : lin_b[i];
    endfunction

    task automatic model_reset(input int reload);
        for (int i = 0; i < 4; i++) begin
            m_pos[i] = 0;
            m_lin[i] = '0;
        end
        m_gap      = 0;
        gap_reload = reload;
    endtask

    task automatic check_slots(input int w, input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s pos%0d", tag, i + 1), get_pos(w, i), m_pos[i]);
            chk($sformatf("%s linea%0d", tag, i + 1), get_lin(w, i), m_lin[i]);
        end
    endtask

    // One game tick on DUT w with the table's expected step, then one idle clock.
    task automatic do_tick(input int w, input logic [12:0] pts, input int step,
                           input string tag);
        bit         pre_free [4];
        bit         any_free;
        logic [4:0] pat;
        bit         done;
        spawn_t     e;
        any_free = 1'b0;
        done     = 1'b0;
        pat      = (m_lfsr[4:0] == 5'd0) ? 5'd1 : m_lfsr[4:0];
        for (int i = 0; i < 4; i++) begin
            pre_free[i] = (m_pos[i] == 0);
            any_free    = any_free | pre_free[i];
        end
        for (int i = 0; i < 4; i++) begin
            if (m_pos[i] == 479) begin
                m_pos[i] = 0;
                m_lin[i] = '0;
            end else if (m_pos[i] != 0) begin
                m_pos[i] = (m_pos[i] + step > 479) ? 479 : m_pos[i] + step;
            end
        end
        if (m_gap == 0 && any_free) begin
            for (int i = 0; i < 4; i++) begin
                if (pre_free[i] && !done) begin
                    m_pos[i] = 1;
                    m_lin[i] = pat;
                    sb.push_back('{slot: i, pat: pat});
                    done = 1'b1;
                end
            end
            m_gap = gap_reload - 1;
        end else if (m_gap > 0) begin
            m_gap--;
        end
        if (w == 0) begin bus_a.puntuacion = pts; bus_a.tick = 1'b1; end
        else        begin bus_b.puntuacion = pts; bus_b.tick = 1'b1; end
        @(posedge clk); #1;
        bus_a.tick = 1'b0;
        bus_b.tick = 1'b0;
        check_slots(w, tag);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s spawn pattern slot%0d", tag, e.slot + 1),
                get_lin(w, e.slot), e.pat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n;
        ph[0] = '{pts: 13'd0,    step: 1, nticks: 480};
        ph[1] = '{pts: 13'd15,   step: 1, nticks: 5};
        ph[2] = '{pts: 13'd16,   step: 2, nticks: 25};
        ph[3] = '{pts: 13'd47,   step: 3, nticks: 25};
        ph[4] = '{pts: 13'd200,  step: 4, nticks: 30};
        ph[5] = '{pts: 13'd8191, step: 4, nticks: 10};

        bus_a.tick = 1'b0; bus_a.start = 1'b0; bus_a.perdio = 1'b0; bus_a.puntuacion = '0;
        bus_b.tick = 1'b0; bus_b.start = 1'b0; bus_b.perdio = 1'b0; bus_b.puntuacion = '0;
        reset = 1'b1;
        model_reset(40);
        repeat (3) @(posedge clk);
        #1;
        chk("reset estado", bus_a.estado, 0);
        chk("reset clear_score", bus_a.clear_score, 0);
        chk("reset jugando", bus_a.jugando, 0);
        check_slots(0, "reset");
        reset = 1'b0;

        // Start pulse; perdio asserted throughout START must be ignored.
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start  = 1'b0;
        bus_a.perdio = 1'b1;
        chk("start1 estado", bus_a.estado, 1);
        chk("start1 clear_score", bus_a.clear_score, 1);
        chk("start1 jugando", bus_a.jugando, 0);
        @(posedge clk); #1;
        chk("start2 estado", bus_a.estado, 1);
        chk("start2 clear_score", bus_a.clear_score, 1);
        @(posedge clk); #1;
        bus_a.perdio = 1'b0;
        chk("play estado", bus_a.estado, 2);
        chk("play jugando", bus_a.jugando, 1);
        chk("play clear_score", bus_a.clear_score, 0);

        // Align the first tick with the LFSR sitting at its seed value.
        n = 0;
        while (m_lfsr != 8'hA5 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (m_lfsr != 8'hA5) begin
            checks++;
            errors++;
            $display("FAIL lfsr align: got %0d expected %0d", m_lfsr, 8'hA5);
        end
        do_tick(0, 13'd0, 1, "a1");
        chk("first posL1", pos_a[0], 1);
        chk("first linea1", lin_a[0], 5'b00101);
        k = 1;

        for (int p = 0; p < 6; p++) begin
            for (int t = 0; t < ph[p].nticks; t++) begin
                k++;
                do_tick(0, ph[p].pts, ph[p].step, $sformatf("a%0d", k));
                if (k == 40)  chk("slot2 empty at tick 40", pos_a[1], 0);
                if (k == 41)  chk("slot2 spawn at tick 41", pos_a[1], 1);
                if (k == 479) chk("posL1 at bottom", pos_a[0], 479);
                if (k == 480) chk("posL1 retired", pos_a[0], 0);
                if (k == 480) chk("linea1 retired", lin_a[0], 0);
                if (k == 481) chk("posL1 respawn", pos_a[0], 1);
            end
        end

        // perdio together with tick: game over, nothing moves.
        bus_a.perdio = 1'b1;
        bus_a.tick   = 1'b1;
        @(posedge clk); #1;
        bus_a.tick = 1'b0;
        chk("over estado", bus_a.estado, 3);
        chk("over jugando", bus_a.jugando, 0);
        check_slots(0, "over");
        bus_a.tick = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus_a.tick = 1'b0;
        chk("frozen estado", bus_a.estado, 3);
        check_slots(0, "frozen");

        // Restart with the stale perdio still high.
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        chk("restart1 estado", bus_a.estado, 1);
        chk("restart1 clear_score", bus_a.clear_score, 1);
        @(posedge clk); #1;
        chk("restart2 estado", bus_a.estado, 1);
        chk("restart2 clear_score", bus_a.clear_score, 1);
        @(posedge clk); #1;
        bus_a.perdio = 1'b0;
        chk("replay estado", bus_a.estado, 2);
        chk("replay clear_score", bus_a.clear_score, 0);
        model_reset(40);
        check_slots(0, "cleared");
        do_tick(0, 13'd0, 1, "replay1");

        // SPAWN_GAP=1 instance: fill all slots, then check retire/respawn spacing.
        model_reset(1);
        bus_b.start = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        chk("b start estado", bus_b.estado, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("b play estado", bus_b.estado, 2);
        for (int t = 1; t <= 125; t++) begin
            do_tick(1, 13'd200, 4, $sformatf("b%0d", t));
            if (t == 120) chk("b posL1 at 477", pos_b[0], 477);
            if (t == 121) chk("b posL1 clamped", pos_b[0], 479);
            if (t == 122) chk("b posL1 retired", pos_b[0], 0);
            if (t == 123) chk("b posL1 respawn next tick", pos_b[0], 1);
            if (t == 123) chk("b posL2 not respawned same tick", pos_b[1], 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
